coherent_averager: RTL and testbench
====================================

Name: coherent_averager

Overview:
- Downstream consumer of the sumador adder output y (W_IN = Q1+Q2 bits, unsigned) in the lock-in coherent-average chain.
- Accumulates 2^LOG2_M consecutive frames of N_POINTS samples point-by-point into an internal accumulator memory.
- Streams out the per-point average (accumulator >> LOG2_M) over a valid/ready handshake.
- Sits between the adder and the readout/FIFO stage.

Parameters:
- W_IN, 50, input sample width (Q1+Q2 of the upstream adder)
- N_POINTS, 256, samples per frame (period length)
- ADDR_W, 8, point index width; N_POINTS <= 2^ADDR_W
- LOG2_M, 4, log2 of frames averaged; accumulator width ACC_W = W_IN+LOG2_M

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a new average
- in_data  in  W_IN  sample from adder y, unsigned
- in_valid  in  1  in_data qualifier
- busy  out  1  high from accepted start until last output transferred
- out_data  out  W_IN  averaged point value
- out_index  out  ADDR_W  point index of out_data
- out_valid  out  1  out_data/out_index valid
- out_ready  in  1  downstream accept
- done  out  1  one-cycle pulse after final output transfer

Behaviour:
- Reset (sync, active-high): state IDLE; busy=0, out_valid=0, done=0, out_data=0, out_index=0, point/frame counters=0. Memory contents undefined; always cleared before use.
- FSM states: IDLE, CLEAR, ACCUM, DUMP.
- IDLE: start=1 -> CLEAR, busy=1 next cycle. in_valid ignored.
- CLEAR: writes 0 to one address per cycle, 0..N_POINTS-1 (N_POINTS cycles), then -> ACCUM with point=0, frame=0. in_valid ignored.
- ACCUM: on in_valid=1, mem[point] <= mem[point] + in_data (zero-extended to ACC_W; no overflow possible). Single-cycle read-modify-write with combinational read, so back-to-back valids are legal. in_valid=0 holds all state.
- ACCUM counters: point wraps N_POINTS-1 -> 0 and frame increments. When the sample at point=N_POINTS-1 with frame=2^LOG2_M-1 is accepted -> DUMP, index=0.
- DUMP timing: out_valid rises the cycle after entering DUMP. out_data = mem[index] >> LOG2_M (truncate), out_index = index, both registered.
- DUMP handshake: transfer when out_valid && out_ready; next index presented the following cycle, so throughput is 1 per 2 cycles max. out_data/out_index are held stable while out_valid && !out_ready.
- DUMP exit: after the transfer of index N_POINTS-1, out_valid=0, done=1 for one cycle, busy=0, -> IDLE.
- start while busy: ignored.
- start and reset in the same cycle: reset wins.
- Reset mid-operation: immediate IDLE with the reset values above; the next start re-clears memory.
- Latency, start to first out_valid (no input gaps): N_POINTS + N_POINTS*2^LOG2_M + 2 cycles.

Optional Feature:
- Macro COH_AVG_ROUND_EN.
- Defined: out_data = (mem[index] + 2^(LOG2_M-1)) >> LOG2_M, i.e. round-half-up. Carry fits in ACC_W+1 internally; result truncated to W_IN. Saturate to all-ones if the rounded value exceeds 2^W_IN-1.
- Undefined: plain truncating shift.
- Timing is identical in both builds.

Decomposition:
- Package coh_avg_pkg: FSM state enum (IDLE, CLEAR, ACCUM, DUMP); ACC_W localparam function; rounding-constant helper.
- One sub-module, coh_avg_mem: N_POINTS x ACC_W register array, one combinational read port, one synchronous write port (we, waddr, wdata).
- Counters, FSM and output register stay in coherent_averager.

Test Plan (bench uses N_POINTS=4, ADDR_W=2, LOG2_M=2, W_IN=50):
- Constant input: start, then 16 back-to-back samples of 100, out_ready=1 -> 4 outputs, each 100, indices 0,1,2,3; done pulses once; busy falls the same cycle.
- Ramp truncation: sample(k,f) = 8k+f, f=0..3 -> sums 32k+6; outputs 1, 9, 17, 25. With COH_AVG_ROUND_EN: 2, 10, 18, 26.
- Gapped input and stall: in_valid toggled 1/0 on every sample. out_ready held low for 5 cycles on index 2 -> same values as the constant case; out_data/out_index stable during the stall; no lost or duplicated index.
- Reset mid-ACCUM: reset after 7 samples of 100, then a fresh start with 16 samples of 40 -> outputs all 40, indicating memory was re-cleared.
- Ignored events: in_valid pulses during IDLE/CLEAR and a second start during ACCUM -> no effect; output matches the constant-100 case; exactly one done.
- Max value: 16 samples of 2^50-1 -> outputs 2^50-1. Under COH_AVG_ROUND_EN also 2^50-1 (saturated, no wrap).

Source files
------------

// File: rtl/coh_avg_pkg.sv
// Shared types and helpers for the coherent averager: FSM state encoding,
// accumulator width and the round-half-up constant.
package coh_avg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DUMP
    } state_t;

    function automatic int acc_width(input int w_in, input int log2_m);
        return w_in + log2_m;
    endfunction

    // Half of one LSB of the averaged result, expressed at accumulator scale.
    function automatic int round_const(input int log2_m);
        return (log2_m > 0) ? (1 << (log2_m - 1)) : 0;
    endfunction

endpackage

// File: rtl/coh_avg_mem.sv
// Accumulator storage: register array with one combinational read port and
// one synchronous write port. Contents are not reset; the owner clears them.
module coh_avg_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 54
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/coherent_averager.sv
// Point-by-point coherent average over 2^LOG2_M frames of N_POINTS samples,
// streamed out over valid/ready. Define COH_AVG_ROUND_EN for round-half-up output.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// CLEAR | zeroing one accumulator word per cycle
// ACCUM | adding each valid sample into mem[point]
// DUMP  | presenting mem[point] >> LOG2_M, one transfer per two cycles
module coherent_averager
    import coh_avg_pkg::*;
#(
    parameter int W_IN     = 50,
    parameter int N_POINTS = 256,
    parameter int ADDR_W   = 8,
    parameter int LOG2_M   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [W_IN-1:0]   in_data,
    input  logic              in_valid,
    output logic              busy,
    output logic [W_IN-1:0]   out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    localparam int ACC_W   = acc_width(W_IN, LOG2_M);
    localparam int FRAME_W = (LOG2_M > 0) ? LOG2_M : 1;
    localparam logic [ADDR_W-1:0]  POINT_LAST = ADDR_W'(N_POINTS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'((1 << LOG2_M) - 1);

    state_t             state, state_next;
    logic [ADDR_W-1:0]  point;
    logic [FRAME_W-1:0] frame;
    logic               mem_we;
    logic [ACC_W-1:0]   mem_wdata;
    logic [ACC_W-1:0]   mem_rdata;
    logic [W_IN-1:0]    avg;

    // The point counter doubles as clear address, accumulate address and dump index.
    coh_avg_mem #(
        .DEPTH  (N_POINTS),
        .ADDR_W (ADDR_W),
        .DATA_W (ACC_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (point),
        .wdata (mem_wdata),
        .raddr (point),
        .rdata (mem_rdata)
    );

`ifdef COH_AVG_ROUND_EN
    localparam int RND_W = ACC_W + 1;
    logic [RND_W-1:0] rounded;

    always_comb begin
        rounded = {1'b0, mem_rdata} + RND_W'(round_const(LOG2_M));
        if (rounded[RND_W-1]) begin
            avg = '1;
        end else begin
            avg = rounded[RND_W-2:LOG2_M];
        end
    end
`else
    always_comb begin
        avg = mem_rdata[ACC_W-1:LOG2_M];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                mem_we = 1'b1;
                if (point == POINT_LAST) state_next = ACCUM;
            end
            ACCUM: begin
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = mem_rdata + ACC_W'(in_data);
                    if (point == POINT_LAST && frame == FRAME_LAST) state_next = DUMP;
                end
            end
            DUMP: begin
                if (out_valid && out_ready && point == POINT_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            point     <= '0;
            frame     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    point <= '0;
                    frame <= '0;
                end
                CLEAR: begin
                    point <= (point == POINT_LAST) ? '0 : point + 1'b1;
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (point == POINT_LAST) begin
                            point <= '0;
                            frame <= frame + 1'b1;
                        end else begin
                            point <= point + 1'b1;
                        end
                    end
                end
                DUMP: begin
                    // Load on the idle cycle, retire on the transfer cycle.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= avg;
                        out_index <= point;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (point == POINT_LAST) begin
                            done <= 1'b1;
                        end else begin
                            point <= point + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coherent_averager.sv
// Self-checking bench for coherent_averager (N_POINTS=4, LOG2_M=2); honours COH_AVG_ROUND_EN.
module tb_coherent_averager;

    localparam int W_IN     = 50;
    localparam int N_POINTS = 4;
    localparam int ADDR_W   = 2;
    localparam int LOG2_M   = 2;
    localparam int M        = 4;
    localparam int N_SMP    = N_POINTS * M;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [W_IN-1:0]   in_data;
    logic              in_valid;
    logic              busy;
    logic [W_IN-1:0]   out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_valid;
    logic              out_ready;
    logic              done;

    coherent_averager #(
        .W_IN     (W_IN),
        .N_POINTS (N_POINTS),
        .ADDR_W   (ADDR_W),
        .LOG2_M   (LOG2_M)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .busy      (busy),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [W_IN-1:0]   smp [N_SMP];
    logic [W_IN-1:0]   obs_d [8];
    logic [ADDR_W-1:0] obs_i [8];
    int n_xfer, done_cnt, done_busy_bad, stall_bad, stall_cnt, first_valid, start_cyc;
    logic              stall_pend;
    logic [W_IN-1:0]   stall_d;
    logic [ADDR_W-1:0] stall_i;
    logic              busy_after_start;

    always @(posedge clk) cyc++;

    // Observer: records transfers, done pulses and stall stability.
    always @(negedge clk) begin
        if (stall_pend) begin
            if (!(out_valid === 1'b1 && out_data === stall_d && out_index === stall_i)) stall_bad++;
        end
        stall_pend = out_valid && !out_ready;
        if (stall_pend) begin
            stall_d = out_data;
            stall_i = out_index;
            stall_cnt++;
        end
        if (out_valid && out_ready) begin
            if (n_xfer < 8) begin
                obs_d[n_xfer] = out_data;
                obs_i[n_xfer] = out_index;
            end
            n_xfer++;
        end
        if (done) begin
            done_cnt++;
            if (busy !== 1'b0) done_busy_bad++;
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
    end

    // Reference: average of the M samples that land on point k.
    function automatic logic [W_IN-1:0] expect_avg(input int k);
        logic [W_IN+2:0] sum;
        logic [W_IN+2:0] q;
        sum = '0;
        for (int f = 0; f < M; f++) sum = sum + (W_IN+3)'(smp[f*N_POINTS + k]);
`ifdef COH_AVG_ROUND_EN
        q = (sum + (W_IN+3)'(M/2)) / (W_IN+3)'(M);
`else
        q = sum / (W_IN+3)'(M);
`endif
        if (q > (W_IN+3)'({W_IN{1'b1}})) return '1;
        return q[W_IN-1:0];
    endfunction

    function automatic logic [W_IN-1:0] rand50();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W_IN-1:0];
    endfunction

    task automatic clear_obs();
        n_xfer = 0; done_cnt = 0; done_busy_bad = 0; stall_bad = 0; stall_cnt = 0;
        first_valid = -1; stall_pend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            obs_d[i] = 'x;
            obs_i[i] = 'x;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // gap_mode: 0 none, 1 toggle, 2 random. ready_mode: 0 always, 1 stall index 2, 2 random.
    task automatic run_avg(input int gap_mode, input int ready_mode, input bit noise, output bit timed_out);
        int i;
        int guard;
        int hold;
        bit v;
        out_ready = 1'b1;
        if (noise) begin
            repeat (2) begin
                in_valid = 1'b1; in_data = rand50();
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        busy_after_start = busy;
        repeat (N_POINTS) begin
            in_valid = noise; in_data = rand50();
            @(posedge clk); #1;
        end
        i = 0; guard = 0;
        while (i < N_SMP && guard < 200) begin
            if (gap_mode == 0)      v = 1'b1;
            else if (gap_mode == 1) v = (guard % 2 == 0);
            else                    v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = v ? smp[i] : rand50();
            start    = noise && (i == 5);
            @(posedge clk); #1;
            if (v) i++;
            guard++;
        end
        in_valid = 1'b0; start = 1'b0;
        guard = 0; hold = 0;
        while (done_cnt == 0 && guard < 300) begin
            if (ready_mode == 1) begin
                out_ready = !(out_valid && out_index == 2'd2 && hold < 5);
                if (!out_ready) hold++;
            end else if (ready_mode == 2) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        timed_out = (done_cnt == 0);
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        vectors++; if (out_index !== '0) begin miscompares++; $display("FAIL reset_out_index: got %0d want 0", out_index); end
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_beats_start: busy got %b want 0", busy); end
    endtask

    task automatic test_constant();
        bit to;
        for (int i = 0; i < N_SMP; i++) smp[i] = 50'd100;
        clear_obs();
        run_avg(0, 0, 1'b0, to);
        vectors++; if (to) begin miscompares++; $display("FAIL const_timeout: done_cnt got %0d want 1", done_cnt); end
        vectors++; if (busy_after_start !== 1'b1) begin miscompares++; $display("FAIL const_busy_rise: got %b want 1", busy_after_start); end
        vectors++; if (first_valid - start_cyc + 1 != N_POINTS + N_SMP + 2) begin
            miscompares++; $display("FAIL const_latency: got %0d want %0d", first_valid - start_cyc + 1, N_POINTS + N_SMP + 2); end
        vectors++; if (n_xfer != N_POINTS) begin miscompares++; $display("FAIL const_xfers: got %0d want %0d", n_xfer, N_POINTS); end
        for (int k = 0; k < N_POINTS; k++) begin
            vectors++; if (obs_d[k] !== expect_avg(k)) begin miscompares++; $display("FAIL const_data[%0d]: got %0d want %0d", k, obs_d[k], expect_avg(k)); end
            vectors++; if (obs_i[k] !== 2'(k)) begin miscompares++; $display("FAIL const_index[%0d]: got %0d want %0d", k, obs_i[k], k); end
        end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL const_done_count: got %0d want 1", done_cnt); end
        vectors++; if (done_busy_bad != 0) begin miscompares++; $display("FAIL const_busy_fall: busy high with done %0d times, want 0", done_busy_bad); end
    endtask

    task automatic test_ramp();
        bit to;
        for (int f = 0; f < M; f++)
            for (int k = 0; k < N_POINTS; k++) smp[f*N_POINTS + k] = 50'(8*k + f);
        clear_obs();
        run_avg(0, 0, 1'b0, to);
        vectors++; if (n_xfer != N_POINTS) begin miscompares++; $display("FAIL ramp_xfers: got %0d want %0d", n_xfer, N_POINTS); end
        for (int k = 0; k < N_POINTS; k++) begin
            vectors++; if (obs_d[k] !== expect_avg(k)) begin miscompares++; $display("FAIL ramp_data[%0d]: got %0d want %0d", k, obs_d[k], expect_avg(k)); end
            vectors++; if (obs_i[k] !== 2'(k)) begin miscompares++; $display("FAIL ramp_index[%0d]: got %0d want %0d", k, obs_i[k], k); end
        end
    endtask

    task automatic test_gap_stall();
        bit to;
        for (int i = 0; i < N_SMP; i++) smp[i] = 50'd100;
        clear_obs();
        run_avg(1, 1, 1'b0, to);
        vectors++; if (n_xfer != N_POINTS) begin miscompares++; $display("FAIL stall_xfers: got %0d want %0d", n_xfer, N_POINTS); end
        for (int k = 0; k < N_POINTS; k++) begin
            vectors++; if (obs_d[k] !== expect_avg(k)) begin miscompares++; $display("FAIL stall_data[%0d]: got %0d want %0d", k, obs_d[k], expect_avg(k)); end
            vectors++; if (obs_i[k] !== 2'(k)) begin miscompares++; $display("FAIL stall_index[%0d]: got %0d want %0d", k, obs_i[k], k); end
        end
        vectors++; if (stall_cnt != 5) begin miscompares++; $display("FAIL stall_cycles: got %0d want 5", stall_cnt); end
        vectors++; if (stall_bad != 0) begin miscompares++; $display("FAIL stall_stable: unstable cycles got %0d want 0", stall_bad); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_obs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (N_POINTS) @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 50'd100;
        repeat (7) @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        for (int i = 0; i < N_SMP; i++) smp[i] = 50'd40;
        clear_obs();
        run_avg(0, 0, 1'b0, to);
        vectors++; if (n_xfer != N_POINTS) begin miscompares++; $display("FAIL midreset_xfers: got %0d want %0d", n_xfer, N_POINTS); end
        for (int k = 0; k < N_POINTS; k++) begin
            vectors++; if (obs_d[k] !== expect_avg(k)) begin miscompares++; $display("FAIL midreset_data[%0d]: got %0d want %0d", k, obs_d[k], expect_avg(k)); end
        end
    endtask

    task automatic test_ignored();
        bit to;
        for (int i = 0; i < N_SMP; i++) smp[i] = 50'd100;
        clear_obs();
        run_avg(0, 0, 1'b1, to);
        vectors++; if (n_xfer != N_POINTS) begin miscompares++; $display("FAIL ignored_xfers: got %0d want %0d", n_xfer, N_POINTS); end
        for (int k = 0; k < N_POINTS; k++) begin
            vectors++; if (obs_d[k] !== expect_avg(k)) begin miscompares++; $display("FAIL ignored_data[%0d]: got %0d want %0d", k, obs_d[k], expect_avg(k)); end
        end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL ignored_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_max();
        bit to;
        for (int i = 0; i < N_SMP; i++) smp[i] = '1;
        clear_obs();
        run_avg(0, 0, 1'b0, to);
        for (int k = 0; k < N_POINTS; k++) begin
            vectors++; if (obs_d[k] !== expect_avg(k)) begin miscompares++; $display("FAIL max_data[%0d]: got %0h want %0h", k, obs_d[k], expect_avg(k)); end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_SMP; i++) smp[i] = rand50();
            clear_obs();
            run_avg(2, 2, 1'b0, to);
            vectors++; if (n_xfer != N_POINTS) begin miscompares++; $display("FAIL rand%0d_xfers: got %0d want %0d", r, n_xfer, N_POINTS); end
            for (int k = 0; k < N_POINTS; k++) begin
                vectors++; if (obs_d[k] !== expect_avg(k)) begin miscompares++; $display("FAIL rand%0d_data[%0d]: got %0h want %0h", r, k, obs_d[k], expect_avg(k)); end
                vectors++; if (obs_i[k] !== 2'(k)) begin miscompares++; $display("FAIL rand%0d_index[%0d]: got %0d want %0d", r, k, obs_i[k], k); end
            end
            vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL rand%0d_done_count: got %0d want 1", r, done_cnt); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_constant();
        test_ramp();
        test_gap_stall();
        test_reset_mid();
        test_ignored();
        test_max();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
